// File: rtl/muldiv_pkg.sv
// Shared types and ALU opcodes for the sequential multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MUL  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REMU = 2'b10,
      OP_RSVD = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      MUL     = 3'd1,
      DIV_CMP = 3'd2,
      DIV_SUB = 3'd3,
      DONE    = 3'd4
   } state_e;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_BGE = 4'b1010;

endpackage

// File: rtl/alu.sv
// Combinational ALU shared by the multiply and divide iterations.
module alu
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]       operation,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic [WIDTH-1:0] result
);

   always_comb begin
      result = '0;
      case (operation)
         ALU_AND: result = src_a & src_b;
         ALU_ADD: result = src_a + src_b;
         ALU_SUB: result = src_a - src_b;
         ALU_BGE: result = WIDTH'(src_a >= src_b);
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative shift-add multiplier and restoring divider around a single ALU.
//
// state   | meaning
// IDLE    | waiting for a request, req_ready high
// MUL     | one shift-add step per cycle, N steps
// DIV_CMP | shift {rem,dvd} left, compare rem against divisor
// DIV_SUB | conditional subtract, shift quotient bit in
// DONE    | result held until consumer handshakes
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_op,
   input  logic [DATA_WIDTH-1:0] req_a,
   input  logic [DATA_WIDTH-1:0] req_b,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_data
);

   localparam int W = DATA_WIDTH;
   localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

   state_e           state;
   op_e              op;
   logic [W-1:0]     acc, mcand, mplier;
   logic [W-1:0]     rem, dvd, divisor;
   logic             ge;
   logic [CNT_W-1:0] cnt;

   logic [3:0]       alu_op;
   logic [W-1:0]     alu_a, alu_b, alu_res;
   logic [W:0]       rem_wide;
   logic [W-1:0]     rem_shift, acc_next, rem_next, quo_next;

   alu #(.WIDTH(W)) u_alu (
      .operation (alu_op),
      .src_a     (alu_a),
      .src_b     (alu_b),
      .result    (alu_res)
   );

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == DONE);

   // rem_wide[W] is the bit shifted out of rem; when set the partial
   // remainder exceeds any W-bit divisor, so the compare must succeed.
   assign rem_wide  = {rem, dvd[W-1]};
   assign rem_shift = rem_wide[W-1:0];
   assign acc_next  = mplier[0] ? alu_res : acc;
   assign rem_next  = ge ? alu_res : rem;
   assign quo_next  = {dvd[W-1:1], ge};

   always_comb begin
      alu_op = ALU_AND;
      alu_a  = '0;
      alu_b  = '0;
      case (state)
         MUL: begin
            alu_op = ALU_ADD;
            alu_a  = acc;
            alu_b  = mcand;
         end
         DIV_CMP: begin
            alu_op = ALU_BGE;
            alu_a  = rem_shift;
            alu_b  = divisor;
         end
         DIV_SUB: begin
            alu_op = ALU_SUB;
            alu_a  = rem;
            alu_b  = divisor;
         end
         default: begin
            alu_op = ALU_AND;
            alu_a  = '0;
            alu_b  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         op        <= OP_MUL;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         rem       <= '0;
         dvd       <= '0;
         divisor   <= '0;
         ge        <= 1'b0;
         cnt       <= '0;
         resp_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op      <= op_e'(req_op);
                  acc     <= '0;
                  rem     <= '0;
                  ge      <= 1'b0;
                  cnt     <= '0;
                  mcand   <= req_a;
                  mplier  <= req_b;
                  dvd     <= req_a;
                  divisor <= req_b;
                  case (op_e'(req_op))
                     OP_MUL:           state <= MUL;
                     OP_DIVU, OP_REMU: state <= DIV_CMP;
                     default: begin
                        state     <= DONE;
                        resp_data <= '0;
                     end
                  endcase
               end
            end
            MUL: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state     <= DONE;
                  resp_data <= acc_next;
               end
            end
            DIV_CMP: begin
               rem   <= rem_shift;
               dvd   <= dvd << 1;
               ge    <= rem_wide[W] | alu_res[0];
               state <= DIV_SUB;
            end
            DIV_SUB: begin
               rem <= rem_next;
               dvd <= quo_next;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state     <= DONE;
                  resp_data <= (op == OP_DIVU) ? quo_next : rem_next;
               end else begin
                  state <= DIV_CMP;
               end
            end
            DONE: begin
               if (resp_ready) begin
                  state     <= IDLE;
                  resp_data <= '0;
               end
            end
            default: begin
               state     <= IDLE;
               resp_data <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed and random checks of muldiv_seq with a response scoreboard.
module tb_muldiv_seq;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] data;
      int          lat;
      string       tag;
   } exp_t;

   exp_t sb[$];

   muldiv_seq #(.DATA_WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] p;
      case (op)
         2'b00: begin
            p = 64'(a) * 64'(b);
            return p[31:0];
         end
         2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         2'b10:   return (b == 0) ? a : a % b;
         default: return 32'h0;
      endcase
   endfunction

   function automatic int op_lat(input logic [1:0] op);
      case (op)
         2'b00:   return 32;
         2'b01:   return 64;
         2'b10:   return 64;
         default: return 0;
      endcase
   endfunction

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string tag);
      exp_t e;
      @(negedge clk);
      check({tag, "_ready_before"}, 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      e.data = exp;
      e.lat  = lat;
      e.tag  = tag;
      sb.push_back(e);
      check({tag, "_busy"}, 64'(req_ready), 64'd0);
   endtask

   // Latency counts rising edges after the accept edge until resp_valid is seen.
   task automatic await_resp();
      exp_t e;
      int   cyc;
      bit   seen;
      e    = sb.pop_front();
      cyc  = 0;
      seen = resp_valid;
      while (!seen && cyc < 300) begin
         @(posedge clk);
         #1;
         cyc++;
         seen = resp_valid;
      end
      check({e.tag, "_seen"}, 64'(seen), 64'd1);
      if (seen) begin
         check({e.tag, "_latency"}, 64'(cyc), 64'(e.lat));
         check({e.tag, "_data"}, 64'(resp_data), 64'(e.data));
         if (resp_ready) begin
            @(posedge clk);
            #1;
            check({e.tag, "_ready_after"}, 64'(req_ready), 64'd1);
            check({e.tag, "_data_cleared"}, 64'(resp_data), 64'd0);
         end
      end
   endtask

   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
      issue(op, a, b, exp, op_lat(op), tag);
      await_resp();
   endtask

   initial begin
      bit stray;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_op     = 2'b00;
      req_a      = '0;
      req_b      = '0;
      resp_ready = 1'b1;

      #12;
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_resp_data", 64'(resp_data), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      do_op(2'b00, 32'd7, 32'd6, 32'd42, "mul_7x6");
      do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_ones");
      do_op(2'b00, 32'h8000_0000, 32'd2, 32'h0000_0000, "mul_wrap");
      do_op(2'b01, 32'd100, 32'd7, 32'd14, "divu_100_7");
      do_op(2'b10, 32'd100, 32'd7, 32'd2, "remu_100_7");
      do_op(2'b01, 32'h1234, 32'd0, 32'hFFFF_FFFF, "divu_by0");
      do_op(2'b10, 32'h1234, 32'd0, 32'h1234, "remu_by0");
      do_op(2'b11, 32'h5555, 32'h7777, 32'h0, "rsvd");
      do_op(2'b01, 32'hFFFF_FFFE, 32'h8000_0001, 32'h1, "divu_bigdiv");
      do_op(2'b10, 32'hFFFF_FFFE, 32'h8000_0001, 32'h7FFF_FFFD, "remu_bigdiv");

      // Consumer stalls while new requests are offered.
      resp_ready = 1'b0;
      do_op(2'b00, 32'd9, 32'd9, 32'd81, "mul_stall");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         req_valid = (i % 2 == 0);
         req_op    = 2'($urandom_range(0, 3));
         req_a     = $urandom;
         req_b     = $urandom;
         @(posedge clk);
         #1;
         check("stall_data", 64'(resp_data), 64'd81);
         check("stall_valid", 64'(resp_valid), 64'd1);
         check("stall_no_accept", 64'(req_ready), 64'd0);
      end
      @(negedge clk);
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("stall_release_ready", 64'(req_ready), 64'd1);
      check("stall_release_valid", 64'(resp_valid), 64'd0);
      stray = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (resp_valid || !req_ready) stray = 1'b1;
      end
      check("stall_no_queued_req", 64'(stray), 64'd0);

      // Reset partway through a divide aborts it.
      issue(2'b01, 32'hFFFF, 32'd3, 32'h5555, 64, "divu_abort");
      void'(sb.pop_back());
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_req_ready", 64'(req_ready), 64'd1);
      check("abort_resp_valid", 64'(resp_valid), 64'd0);
      check("abort_resp_data", 64'(resp_data), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      stray = 1'b0;
      repeat (70) begin
         @(posedge clk);
         #1;
         if (resp_valid) stray = 1'b1;
      end
      check("abort_no_resp", 64'(stray), 64'd0);
      do_op(2'b00, 32'd3, 32'd5, 32'd15, "mul_after_rst");

      for (int i = 0; i < 8; i++) begin
         logic [1:0]  op;
         logic [31:0] a, b;
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
         do_op(op, a, b, model(op, a, b), $sformatf("rand%0d", i));
      end

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width; iteration count N = DATA_WIDTH.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  block can accept request.
REQ-006 SHALL have port req_op  input  2  00 MUL (low word), 01 DIVU, 10 REMU, 11 reserved.
REQ-007 SHALL have port req_a  input  DATA_WIDTH  multiplicand / dividend.
REQ-008 SHALL have port req_b  input  DATA_WIDTH  multiplier / divisor.
REQ-009 SHALL have port resp_valid  output  1  result present.
REQ-010 SHALL have port resp_ready  input  1  consumer accepts result.
REQ-011 SHALL have port resp_data  output  DATA_WIDTH  result.

Function
REQ-012 SHALL be an FSM with states IDLE, MUL, DIV_CMP, DIV_SUB, DONE; ALU used once per cycle.
REQ-013 SHALL drive req_ready = (state==IDLE), resp_valid = (state==DONE), both from state register only.
REQ-014 SHALL accept on edge where req_valid & req_ready; latch req_op, req_a, req_b; clear accumulator/remainder; counter = 0.
REQ-015 SHALL ignore req_valid in all non-IDLE states; no queueing.
REQ-016 MUL: each MUL cycle ALU op ADD (4'b0010), SrcA = acc, SrcB = mcand; acc <= ALUResult if mplier[0] else acc; mcand <<= 1; mplier >>= 1; counter++.
REQ-017 MUL SHALL leave MUL after N cycles -> DONE; resp_valid first high N cycles after accept edge; result = low DATA_WIDTH bits of product, wrap-around.
REQ-018 DIV_CMP: shift {rem,dvd} left 1; ALU op BGE (4'b1010, unsigned) with SrcA = shifted rem, SrcB = divisor; latch ge flag -> DIV_SUB.
REQ-019 DIV_SUB: ALU op SUB (4'b0110) on same operands; rem <= ALUResult if ge else unchanged; quotient bit0 <= ge; counter++; -> DIV_CMP, or DONE after N-th iteration.
REQ-020 DIVU/REMU SHALL take exactly 2N cycles; resp_valid first high 2N cycles after accept edge.
REQ-021 Divide by zero SHALL need no special path: DIVU -> all-ones, REMU -> dividend (RISC-V semantics).
REQ-022 Reserved op 11 SHALL go IDLE -> DONE on accept edge with resp_data = 0.
REQ-023 DONE SHALL hold resp_data stable while resp_ready low; on resp_valid & resp_ready -> IDLE; req_ready high next cycle (no same-cycle bypass).
REQ-024 resp_data SHALL be 0 outside DONE.
REQ-025 ALU Operation SHALL be AND (4'b0000) with zero operands in IDLE/DONE.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, counter 0, all operand/acc/rem/quotient regs 0; req_ready=1, resp_valid=0, resp_data=0.
REQ-027 Reset mid-operation SHALL abort the operation with no response; first request after release accepted normally.

Structure
REQ-028 SHALL use package muldiv_pkg: op enum (MUL, DIVU, REMU, RSVD), state enum, ALU opcode constants ALU_AND/ALU_ADD/ALU_SUB/ALU_BGE.
REQ-029 SHALL instantiate the existing alu as its single sub-module; counter width $clog2(DATA_WIDTH)+1.

Verification
REQ-030 MUL 7 x 6, resp_ready=1 -> resp_valid exactly 32 cycles after accept, resp_data=42, req_ready back 1 cycle later.
REQ-031 MUL 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001; MUL 0x80000000 x 2 -> 0x00000000.
REQ-032 DIVU 100/7 -> 14 and REMU 100/7 -> 2, each 64 cycles after accept.
REQ-033 DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234; op 11 -> 0 one cycle after accept.
REQ-034 resp_ready low 5 cycles in DONE, req_valid toggling -> resp_data stable, no new accept; accept only after handshake.
REQ-035 rst_n low at cycle 10 of DIVU -> immediate IDLE, outputs zero, no response; next MUL 3 x 5 -> 15.
